gantry_sequencer: RTL and testbench



---
 rtl/gantry_sequencer.sv | 135 +++++++++++++
 tb/tb_gantry_sequencer.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/gantry_sequencer.sv
// gantry_sequencer: joystick/controller commands to rate-limited X/Y/Z step pulses with position tracking.
// Optional DIAG_MOVE_EN lets X and Y step on the same tick; otherwise X takes precedence over Y.
module gantry_sequencer #(
  parameter int STEP_DIV = 1000,
  parameter int X_MAX    = 200,
  parameter int Y_MAX    = 200,
  parameter int Z_MAX    = 100,
  parameter int POS_W    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             Mov_l,
  input  logic             Mov_r,
  input  logic             Mov_f,
  input  logic             Mov_b,
  input  logic             Un_claw,
  input  logic             Down,
  input  logic             Rise,
  input  logic             Return,
  input  logic             Contact,
  output logic             Step_x,
  output logic             Step_y,
  output logic             Step_z,
  output logic             Dir_x,
  output logic             Dir_y,
  output logic             Dir_z,
  output logic [POS_W-1:0] Pos_x,
  output logic [POS_W-1:0] Pos_y,
  output logic [POS_W-1:0] Pos_z,
  output logic             Top,
  output logic             Origin,
  output logic             Touch,
  output logic             Busy
);
  localparam int CW = $clog2(STEP_DIV);
  localparam logic [CW-1:0] LAST = CW'(STEP_DIV - 1);
  localparam logic [POS_W-1:0] XM = POS_W'(X_MAX);
  localparam logic [POS_W-1:0] YM = POS_W'(Y_MAX);
  localparam logic [POS_W-1:0] ZM = POS_W'(Z_MAX);

  typedef enum logic [2:0] {IDLE, JOG, DESCEND, ASCEND, HOME_Z, HOME_XY} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             contact_m_q, contact_s_q;
  logic [POS_W-1:0] pos_x_q, pos_x_d, pos_y_q, pos_y_d, pos_z_q, pos_z_d;
  logic             step_x_q, step_x_d, step_y_q, step_y_d, step_z_q, step_z_d;
  logic             dir_x_q, dir_x_d, dir_y_q, dir_y_d, dir_z_q, dir_z_d;
  logic             tick, top, origin, touch, jog_req, jog, home_xy;
  logic             x_inc, x_dec, y_inc, y_dec, z_inc, z_dec, x_go, y_go, z_go;

  always_comb begin
    tick    = cnt_q == LAST;
    cnt_d   = tick ? '0 : cnt_q + 1'b1;
    top     = pos_z_q == '0;
    origin  = top && pos_x_q == '0 && pos_y_q == '0;
    touch   = pos_z_q == ZM || contact_s_q;
    jog_req = !Un_claw && (Mov_l || Mov_r || Mov_f || Mov_b);
    state_d = Return  ? (origin ? IDLE : (top ? HOME_XY : HOME_Z)) :
              Rise    ? ASCEND :
              Down    ? DESCEND :
              jog_req ? JOG : IDLE;
    jog     = state_d == JOG;
    home_xy = state_d == HOME_XY;
    // Each request is only raised when the resulting position stays in range
    x_inc   = jog && Mov_r && !Mov_l && pos_x_q < XM;
    x_dec   = ((jog && Mov_l && !Mov_r) || home_xy) && pos_x_q != '0;
    y_inc   = jog && Mov_f && !Mov_b && pos_y_q < YM;
    y_dec   = ((jog && Mov_b && !Mov_f) || home_xy) && pos_y_q != '0;
    z_inc   = state_d == DESCEND && !touch && pos_z_q < ZM;
    z_dec   = (state_d == ASCEND || state_d == HOME_Z) && !top;
    x_go    = tick && (x_inc || x_dec);
`ifdef DIAG_MOVE_EN
    y_go    = tick && (y_inc || y_dec);
`else
    y_go    = tick && (y_inc || y_dec) && !(x_inc || x_dec);
`endif
    z_go    = tick && (z_inc || z_dec);
    pos_x_d  = x_go ? (x_inc ? pos_x_q + 1'b1 : pos_x_q - 1'b1) : pos_x_q;
    pos_y_d  = y_go ? (y_inc ? pos_y_q + 1'b1 : pos_y_q - 1'b1) : pos_y_q;
    pos_z_d  = z_go ? (z_inc ? pos_z_q + 1'b1 : pos_z_q - 1'b1) : pos_z_q;
    dir_x_d  = x_go ? x_inc : dir_x_q;
    dir_y_d  = y_go ? y_inc : dir_y_q;
    dir_z_d  = z_go ? z_inc : dir_z_q;
    step_x_d = x_go;
    step_y_d = y_go;
    step_z_d = z_go;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      contact_m_q <= 1'b0;
      contact_s_q <= 1'b0;
      pos_x_q     <= '0;
      pos_y_q     <= '0;
      pos_z_q     <= '0;
      step_x_q    <= 1'b0;
      step_y_q    <= 1'b0;
      step_z_q    <= 1'b0;
      dir_x_q     <= 1'b0;
      dir_y_q     <= 1'b0;
      dir_z_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      contact_m_q <= Contact;
      contact_s_q <= contact_m_q;
      pos_x_q     <= pos_x_d;
      pos_y_q     <= pos_y_d;
      pos_z_q     <= pos_z_d;
      step_x_q    <= step_x_d;
      step_y_q    <= step_y_d;
      step_z_q    <= step_z_d;
      dir_x_q     <= dir_x_d;
      dir_y_q     <= dir_y_d;
      dir_z_q     <= dir_z_d;
    end
  end

  assign Step_x = step_x_q;
  assign Step_y = step_y_q;
  assign Step_z = step_z_q;
  assign Dir_x  = dir_x_q;
  assign Dir_y  = dir_y_q;
  assign Dir_z  = dir_z_q;
  assign Pos_x  = pos_x_q;
  assign Pos_y  = pos_y_q;
  assign Pos_z  = pos_z_q;
  assign Top    = top;
  assign Origin = origin;
  assign Touch  = touch;
  assign Busy   = state_q != IDLE;
endmodule

// File: tb/tb_gantry_sequencer.sv
// tb_gantry_sequencer: scoreboard bench with a per-cycle reference model of the gantry sequencer.
module tb_gantry_sequencer;
  localparam int DIV = 4, XM = 6, YM = 5, ZM = 9;

  logic clk = 0, rst_n = 0;
  logic Mov_l = 0, Mov_r = 0, Mov_f = 0, Mov_b = 0, Un_claw = 0;
  logic Down = 0, Rise = 0, Return = 0, Contact = 0;
  logic Step_x, Step_y, Step_z, Dir_x, Dir_y, Dir_z, Top, Origin, Touch, Busy;
  logic [7:0] Pos_x, Pos_y, Pos_z;

  gantry_sequencer #(.STEP_DIV(DIV), .X_MAX(XM), .Y_MAX(YM), .Z_MAX(ZM), .POS_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .Mov_l(Mov_l), .Mov_r(Mov_r), .Mov_f(Mov_f), .Mov_b(Mov_b),
    .Un_claw(Un_claw), .Down(Down), .Rise(Rise), .Return(Return), .Contact(Contact),
    .Step_x(Step_x), .Step_y(Step_y), .Step_z(Step_z), .Dir_x(Dir_x), .Dir_y(Dir_y), .Dir_z(Dir_z),
    .Pos_x(Pos_x), .Pos_y(Pos_y), .Pos_z(Pos_z), .Top(Top), .Origin(Origin), .Touch(Touch), .Busy(Busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [23:0] pos;
    logic [2:0]  st;
    logic [2:0]  dr;
    logic [3:0]  fl;
  } rec_t;

  rec_t q[$];
  rec_t e;
  int checks = 0, errors = 0, nsx = 0, nsz = 0;
  int mx, my, mz, mcnt;
  bit msx, msy, msz, mdx, mdy, mdz, mcm, mcs, mbusy;

  task automatic check(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
    end
  endtask

  function automatic rec_t snap();
    rec_t r;
    r.pos = {8'(mx), 8'(my), 8'(mz)};
    r.st  = {msx, msy, msz};
    r.dr  = {mdx, mdy, mdz};
    r.fl  = {mz == 0, mx == 0 && my == 0 && mz == 0, mz == ZM || mcs, mbusy};
    return r;
  endfunction

  task automatic model_reset();
    mx = 0; my = 0; mz = 0; mcnt = 0;
    {msx, msy, msz, mdx, mdy, mdz, mcm, mcs, mbusy} = '0;
  endtask

  // One clock of the reference behaviour, using the inputs currently applied
  task automatic model_step();
    int dx, dy, dz;
    bit tick, org, tch, act;
    tick = mcnt == DIV - 1;
    org  = mx == 0 && my == 0 && mz == 0;
    tch  = mz == ZM || mcs;
    dx = 0; dy = 0; dz = 0; act = 0;
    if (Return) begin
      act = !org;
      if (mz > 0) dz = -1;
      else begin
        dx = mx > 0 ? -1 : 0;
        dy = my > 0 ? -1 : 0;
      end
    end else if (Rise) begin
      act = 1; dz = mz > 0 ? -1 : 0;
    end else if (Down) begin
      act = 1; dz = (!tch && mz < ZM) ? 1 : 0;
    end else if (!Un_claw && (Mov_l || Mov_r || Mov_f || Mov_b)) begin
      act = 1;
      dx = int'(Mov_r) - int'(Mov_l);
      dy = int'(Mov_f) - int'(Mov_b);
      if (mx + dx < 0 || mx + dx > XM) dx = 0;
      if (my + dy < 0 || my + dy > YM) dy = 0;
    end
`ifndef DIAG_MOVE_EN
    if (dx != 0) dy = 0;
`endif
    if (!tick) begin dx = 0; dy = 0; dz = 0; end
    msx = dx != 0; msy = dy != 0; msz = dz != 0;
    if (msx) mdx = dx > 0;
    if (msy) mdy = dy > 0;
    if (msz) mdz = dz > 0;
    mx += dx; my += dy; mz += dz;
    mbusy = act;
    mcnt = tick ? 0 : mcnt + 1;
    mcs = mcm; mcm = Contact;
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      model_step();
      q.push_back(snap());
      @(posedge clk); #2;
    end
  endtask

  task automatic clear_in();
    {Mov_l, Mov_r, Mov_f, Mov_b, Un_claw, Down, Rise, Return, Contact} = '0;
  endtask

  task automatic do_reset();
    rst_n = 0;
    clear_in();
    model_reset();
    q.delete();
    @(posedge clk); #2;
    @(posedge clk); #2;
    rst_n = 1;
    q.push_back(snap());
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      check("reset_pos", {Pos_x, Pos_y, Pos_z}, 0);
      check("reset_step_dir", {Step_x, Step_y, Step_z, Dir_x, Dir_y, Dir_z}, 0);
      check("reset_flags", {Top, Origin, Touch, Busy}, 4'b1100);
    end else if (q.size() == 0) begin
      checks++; errors++;
      $display("FAIL scoreboard_empty: got no expectation for DUT output at %0t", $time);
    end else begin
      e = q.pop_front();
      check("pos", {Pos_x, Pos_y, Pos_z}, e.pos);
      check("step", {Step_x, Step_y, Step_z}, e.st);
      check("dir", {Dir_x, Dir_y, Dir_z}, e.dr);
      check("flags", {Top, Origin, Touch, Busy}, e.fl);
      nsx += int'(Step_x);
      nsz += int'(Step_z);
    end
  end

  initial begin
    int base, k;
    do_reset();
    // Jog right for 12 clocks
    base = nsx; Mov_r = 1; cyc(12);
    check("jog_pos_x", Pos_x, 3);
    check("jog_dir_x", Dir_x, 1);
    clear_in(); cyc(1);
    check("jog_pulses", nsx - base, 3);
    // Joystick locked
    do_reset(); base = nsx; Un_claw = 1; Mov_r = 1; cyc(12);
    check("lock_pos_x", Pos_x, 0);
    clear_in(); cyc(1);
    check("lock_pulses", nsx - base, 0);
    // Clamp at X_MAX, then opposing requests
    do_reset(); base = nsx; Mov_r = 1; cyc(40);
    check("clamp_pos_x", Pos_x, XM);
    clear_in(); cyc(1);
    check("clamp_pulses", nsx - base, XM);
    base = nsx; Mov_l = 1; Mov_r = 1; cyc(12);
    check("oppose_pos_x", Pos_x, XM);
    clear_in(); cyc(1);
    check("oppose_pulses", nsx - base, 0);
    // Descend until contact
    do_reset(); Down = 1; k = 0;
    while (mz < 5 && k < 100) begin cyc(1); k++; end
    Contact = 1; cyc(40);
    check("contact_pos_z", Pos_z, 5);
    check("contact_touch", Touch, 1);
    // Descend to the floor
    do_reset(); base = nsz; Down = 1; cyc(60);
    check("floor_pos_z", Pos_z, ZM);
    check("floor_touch", Touch, 1);
    clear_in(); cyc(1);
    check("floor_pulses", nsz - base, ZM);
    // Return home from (4,2,3)
    do_reset(); Mov_r = 1; k = 0;
    while (mx < 4 && k < 100) begin cyc(1); k++; end
    clear_in(); Mov_f = 1;
    while (my < 2 && k < 200) begin cyc(1); k++; end
    clear_in(); Down = 1;
    while (mz < 3 && k < 300) begin cyc(1); k++; end
    check("return_start", {Pos_x, Pos_y, Pos_z}, 24'h040203);
    clear_in(); Return = 1; cyc(44);
    check("return_origin", {Origin, Busy}, 2'b10);
    check("return_pos", {Pos_x, Pos_y, Pos_z}, 0);
    // Priority: Return over Down, Rise over Down
    clear_in(); Down = 1; k = 0;
    while (mz < 3 && k < 100) begin cyc(1); k++; end
    Return = 1; cyc(4);
    check("prio_return_down", Pos_z, 2);
    Return = 0; Rise = 1; cyc(4);
    check("prio_rise_down", Pos_z, 1);
    // Randomized traffic with occasional resets
    repeat (400) begin
      if ($urandom_range(0, 49) == 0) do_reset();
      else begin
        Mov_l   = $urandom_range(0, 9) < 3;
        Mov_r   = $urandom_range(0, 9) < 3;
        Mov_f   = $urandom_range(0, 9) < 3;
        Mov_b   = $urandom_range(0, 9) < 3;
        Un_claw = $urandom_range(0, 9) < 2;
        Down    = $urandom_range(0, 9) < 2;
        Rise    = $urandom_range(0, 9) < 1;
        Return  = $urandom_range(0, 9) < 1;
        Contact = $urandom_range(0, 9) < 1;
      end
      cyc($urandom_range(1, 12));
    end
    clear_in(); cyc(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
